// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency fetch lookup, EX-stage update, saturating lookup/mispredict stats.
module branch_predictor #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_mispredict,
  input  logic             flush_all,
  output logic [CNT_W-1:0] stat_lookups,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic [ENTRIES-1:0] valid_r;
  logic [1:0]         ctr_r    [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [WIDTH-1:0]   target_r [ENTRIES];
  logic [CNT_W-1:0]   lookups_r;
  logic [CNT_W-1:0]   mispred_r;

  logic [IDX-1:0]     if_idx_s;
  logic [TAG_W-1:0]   if_tag_s;
  logic [IDX-1:0]     upd_idx_s;
  logic [TAG_W-1:0]   upd_tag_s;
  logic               upd_hit_s;
  logic [1:0]         upd_ctr_s;
  logic [1:0]         ctr_next_s;
  logic               tgt_write_s;
  logic               unused_ok_s;

  assign if_idx_s    = if_pc[IDX+1:2];
  assign if_tag_s    = if_pc[WIDTH-1:IDX+2];
  assign upd_idx_s   = upd_pc[IDX+1:2];
  assign upd_tag_s   = upd_pc[WIDTH-1:IDX+2];
  assign unused_ok_s = ^{if_pc[1:0], upd_pc[1:0]};

  // Fetch lookup: reads pre-update contents, no bypass from the update port.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = if_pc + {{(WIDTH-3){1'b0}}, 3'd4};
    if (valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s)) begin
      pred_hit   = 1'b1;
      pred_taken = ctr_r[if_idx_s][1];
      if (ctr_r[if_idx_s][1]) begin
        pred_target = target_r[if_idx_s];
      end else begin
        pred_target = if_pc + {{(WIDTH-3){1'b0}}, 3'd4};
      end
    end else begin
      pred_hit = 1'b0;
    end
  end

  // Update-side tag match and saturating counter step.
  always_comb begin
    upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    upd_ctr_s  = ctr_r[upd_idx_s];
    ctr_next_s = upd_ctr_s;
    if (upd_taken) begin
      if (upd_ctr_s != 2'b11) begin
        ctr_next_s = upd_ctr_s + 2'b01;
      end else begin
        ctr_next_s = upd_ctr_s;
      end
    end else begin
      if (upd_ctr_s != 2'b00) begin
        ctr_next_s = upd_ctr_s - 2'b01;
      end else begin
        ctr_next_s = upd_ctr_s;
      end
    end
  end

  // Taken updates always write tag/target; the valid bit gates whether they matter.
  assign tgt_write_s = upd_valid && upd_taken && !flush_all;

  // Valid bits and direction counters; flush only drops valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (flush_all) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= ctr_next_s;
      end else if (upd_taken) begin
        valid_r[upd_idx_s] <= 1'b1;
        ctr_r[upd_idx_s]   <= 2'b10;
      end
    end
  end

  // Tag and target storage needs no reset: entries start invalid.
  always_ff @(posedge clk) begin
    if (tgt_write_s) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= upd_target;
    end
  end

  // Saturating performance counters, untouched by flush_all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_r <= {CNT_W{1'b0}};
      mispred_r <= {CNT_W{1'b0}};
    end else begin
      if (pred_hit && (lookups_r != {CNT_W{1'b1}})) begin
        lookups_r <= lookups_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (upd_valid && upd_mispredict && (mispred_r != {CNT_W{1'b1}})) begin
        mispred_r <= mispred_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_lookups = lookups_r;
  assign stat_mispred = mispred_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against a behavioural BTB model.
module tb_branch_predictor;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0, flush_all = 1'b0;
  logic [31:0] upd_pc = 32'h0, upd_target = 32'h0;
  logic [CW-1:0] stat_lookups, stat_mispred;

  int errors = 0;
  int checks = 0;

  // behavioural model: one record per set
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  int          m_lookups, m_mispred;
  localparam int SAT = (1 << CW) - 1;

  branch_predictor #(.WIDTH(32), .ENTRIES(64), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .flush_all(flush_all), .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 32'd256;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_lookups = 0;
    m_mispred = 0;
  endtask

  // One clock: drive, check lookup/stats, then advance the model at the edge.
  task automatic cyc(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                     input bit ut, input logic [31:0] utgt, input bit um, input bit fl);
    int  s, j;
    bit  e_hit, e_taken;
    logic [31:0] e_tgt;
    if_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_mispredict = um; flush_all = fl;
    #2;
    s       = set_of(pc);
    e_hit   = m_valid[s] && (m_tag[s] == tag_of(pc));
    e_taken = e_hit && (m_ctr[s] >= 2);
    e_tgt   = e_taken ? m_tgt[s] : pc + 32'd4;
    check("pred_hit", 64'(pred_hit), 64'(e_hit));
    check("pred_taken", 64'(pred_taken), 64'(e_taken));
    check("pred_target", 64'(pred_target), 64'(e_tgt));
    check("stat_lookups", 64'(stat_lookups), 64'(m_lookups));
    check("stat_mispred", 64'(stat_mispred), 64'(m_mispred));
    @(posedge clk);
    if (e_hit && m_lookups < SAT) m_lookups++;
    if (uv && um && m_mispred < SAT) m_mispred++;
    if (fl) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      j = set_of(upc);
      if (m_valid[j] && m_tag[j] == tag_of(upc)) begin
        if (ut) begin
          m_ctr[j] = (m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1;
          m_tgt[j] = utgt;
        end else begin
          m_ctr[j] = (m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1;
        end
      end else if (ut) begin
        m_valid[j] = 1'b1;
        m_tag[j]   = tag_of(upc);
        m_tgt[j]   = utgt;
        m_ctr[j]   = 2;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    model_reset();
    // reset state
    if_pc = 32'h40;
    #3;
    check("rst_hit", 64'(pred_hit), 64'd0);
    check("rst_taken", 64'(pred_taken), 64'd0);
    check("rst_target", 64'(pred_target), 64'h44);
    check("rst_lookups", 64'(stat_lookups), 64'd0);
    check("rst_mispred", 64'(stat_mispred), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // allocate 0x40 with same-cycle lookup (no bypass), then hit
    cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
    check("alloc_ctr_wt", 64'(m_ctr[16]), 64'd2);
    cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // saturate up, then walk down to weak-NT
    for (int k = 0; k < 3; k++) cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_taken_after_walk", 64'(pred_taken), 64'd0);
    // conflicting tag at index 16 replaces the entry
    cyc(32'h40, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 1'b0);
    cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("conflict_0x40_miss", 64'(pred_hit), 64'd0);
    cyc(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // flush with simultaneous update: update dropped, stat still counts
    cyc(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 1'b1);
    cyc(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_drop", 64'(pred_hit), 64'd0);
    cyc(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // PC wrap on fall-through
    cyc(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // counter saturation
    for (int k = 0; k < 20; k++) cyc(32'h140, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0);
    check("mispred_sat", 64'(stat_mispred), 64'd15);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      cyc(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
          $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    // asynchronous reset mid-update
    if_pc = 32'h240; upd_valid = 1'b1; upd_pc = 32'h240; upd_taken = 1'b1;
    upd_target = 32'h900; upd_mispredict = 1'b1; flush_all = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_hit", 64'(pred_hit), 64'd0);
    check("midrst_taken", 64'(pred_taken), 64'd0);
    check("midrst_target", 64'(pred_target), 64'h244);
    check("midrst_lookups", 64'(stat_lookups), 64'd0);
    check("midrst_mispred", 64'(stat_mispred), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(32'h240, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
